// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demux: steers each accepted word to one of two one-entry output registers.
// Latency: word accepted at edge k is visible (valid) right after edge k; consumable from edge k+1.
// Backpressure: in_ready follows only the selected port's room, so a stalled port never blocks the other.

module demux1x2_reg_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             room,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   dlv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A delivery with a simultaneous load keeps the slot FULL with the new word.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL:  if (dlv && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        valid = (state == FULL);
        dlv   = valid & ready;
        room  = !valid | ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // Wraps naturally modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (dlv) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

module demux1x2_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    logic room1, room2;
    logic acc, load1, load2;

    // in_valid deliberately kept out of in_ready to avoid a valid->ready loop.
    always_comb begin
        in_ready = in_sel ? room2 : room1;
        acc      = in_valid & in_ready;
        load1    = acc & !in_sel;
        load2    = acc & in_sel;
    end

    demux1x2_reg_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .data      (out1_data),
        .valid     (out1_valid),
        .room      (room1),
        .cnt       (cnt1)
    );

    demux1x2_reg_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot2 (
        .clk       (clk),
        .rst       (rst),
        .load      (load2),
        .load_data (in_data),
        .ready     (out2_ready),
        .data      (out2_data),
        .valid     (out2_valid),
        .room      (room2),
        .cnt       (cnt2)
    );

endmodule

// File: tb/tb_demux1x2_reg.sv
// Bench for demux1x2_reg: directed scenarios plus random traffic against a queue-based model.
module tb_demux1x2_reg;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out1_data, out2_data;
    logic       out1_valid, out2_valid;
    logic       out1_ready = 1'b0;
    logic       out2_ready = 1'b0;
    logic [7:0] cnt1, cnt2;

    int n_chk = 0;
    int n_fail = 0;

    // Model: each port is a queue holding at most one word, plus delivered-word counts.
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int m_cnt1 = 0;
    int m_cnt2 = 0;

    demux1x2_reg dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        check("out1_valid", out1_valid, q1.size() != 0);
        check("out2_valid", out2_valid, q2.size() != 0);
        if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
        if (q2.size() != 0) check("out2_data", out2_data, q2[0]);
        check("cnt1", cnt1, m_cnt1 % 256);
        check("cnt2", cnt2, m_cnt2 % 256);
    endtask

    task automatic model_reset();
        q1.delete();
        q2.delete();
        m_cnt1 = 0;
        m_cnt2 = 0;
    endtask

    task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                         input logic r1, input logic r2);
        logic exp_rdy;
        logic [7:0] tmp;
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; out1_ready = r1; out2_ready = r2;
        #1;
        exp_rdy = s ? (q2.size() == 0 || r2) : (q1.size() == 0 || r1);
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (q1.size() != 0 && r1) begin tmp = q1.pop_front(); m_cnt1++; end
        if (q2.size() != 0 && r2) begin tmp = q2.pop_front(); m_cnt2++; end
        if (v && exp_rdy) begin
            if (s) q2.push_back(d);
            else   q1.push_back(d);
        end
        #1;
        check_outs();
    endtask

    // Reset pulse placed between edges; state must clear without waiting for a clock.
    task automatic mid_reset();
        @(negedge clk);
        in_valid = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_v1", out1_valid, 0);
        check("rst_v2", out2_valid, 0);
        check("rst_c1", cnt1, 0);
        check("rst_c2", cnt2, 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset with the clock stopped.
        #2;
        check("por_v1", out1_valid, 0);
        check("por_v2", out2_valid, 0);
        check("por_d1", out1_data, 0);
        check("por_d2", out2_data, 0);
        check("por_c1", cnt1, 0);
        check("por_c2", cnt2, 0);
        in_sel = 1'b0; #1;
        check("por_rdy0", in_ready, 1);
        in_sel = 1'b1; #1;
        check("por_rdy1", in_ready, 1);
        rst = 1'b0;
        #2;
        clk_en = 1'b1;

        cycle(1, 0, 8'hA5, 0, 0);
        check("first_v1", out1_valid, 1);
        check("first_d1", out1_data, 8'hA5);
        check("first_v2", out2_valid, 0);

        // Backpressure isolation.
        mid_reset();
        cycle(1, 0, 8'h11, 0, 0);
        cycle(1, 0, 8'h22, 0, 0);
        check("bp_hold", out1_data, 8'h11);
        cycle(1, 1, 8'h33, 0, 0);
        check("bp_other", out2_data, 8'h33);
        check("bp_still1", out1_data, 8'h11);

        // Streaming on port 1.
        mid_reset();
        for (int i = 0; i < 10; i++) cycle(1, 0, i[7:0], 1, 0);
        cycle(0, 0, 8'h00, 1, 0);
        check("stream_cnt", cnt1, 10);
        check("stream_empty", out1_valid, 0);

        // Deliver and reload in the same cycle.
        mid_reset();
        cycle(1, 1, 8'h44, 0, 0);
        cycle(1, 1, 8'h55, 0, 1);
        check("reload_d2", out2_data, 8'h55);
        check("reload_v2", out2_valid, 1);
        check("reload_c2", cnt2, 1);

        // Counter wrap.
        mid_reset();
        for (int i = 0; i < 256; i++) cycle(1, 0, i[7:0], 1, 0);
        cycle(0, 0, 8'h00, 1, 0);
        check("wrap_c1", cnt1, 0);
        cycle(1, 0, 8'h5A, 1, 0);
        cycle(0, 0, 8'h00, 1, 0);
        check("wrap_c1b", cnt1, 1);
        check("wrap_c2", cnt2, 0);

        // Mid-operation reset with both ports full.
        cycle(1, 0, 8'h66, 0, 0);
        cycle(1, 1, 8'h77, 0, 0);
        mid_reset();
        cycle(0, 0, 8'h00, 1, 1);
        check("post_rst_c1", cnt1, 0);
        check("post_rst_c2", cnt2, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) mid_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
